memory2: RTL

Second memory stage of the in-order pipeline, directly downstream of the first memory stage and upstream of writeback. It registers the first-memory-stage pass bundle and waits for the dcache read response of any load issued there. It captures that response in a one-entry hold buffer when writeback is stalled, then aligns and sign/zero-extends the load data. It also publishes a forward request to the issue/forwarding logic and propagates exceptions.

---
 rtl/memory2.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/memory2.sv
// memory2: second memory pipeline stage. It registers the memory1 bundle,
// waits for the dcache read response of an outstanding load, holds that
// response while writeback is stalled, then aligns and extends the load
// data. It also drives a forward request and passes exceptions on to writeback.

package cpu_defs_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } byte_type_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ex_out;
        logic        is_mem;
        logic        is_store;
        logic        is_signed;
        byte_type_e  byte_type;
        logic [1:0]  byte_en;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic        dcache_req;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] badv;
    } excp_pass_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic        data_valid;
        logic [31:0] data;
    } forward_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic [31:0] wb_data;
    } memory2_writeback_pass_t;

    // IDLE: no response pending; WAIT: load waiting for dcache data;
    // HELD: data captured while writeback stalls; DROP: flushed load whose
    // response must still be swallowed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HELD = 2'd2,
        ST_DROP = 2'd3
    } mem2_st_e;

endpackage

module memory2
    import cpu_defs_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    stall_i,
    output logic                    stall_o,
    input  memory1_memory2_pass_t   pass_in,
    input  excp_pass_t              excp_pass_in,
    input  logic                    dcache_data_valid,
    input  logic [31:0]             dcache_rd_data,
    output forward_req_t            fwd_req,
    output memory2_writeback_pass_t pass_out,
    output excp_pass_t              excp_pass_out
);

    // Handshake: an instruction moves from pass_in into r on every clock
    // where stall_o is low (or a flush forces the load); pass_out.valid marks
    // the single cycle in which writeback takes the instruction held in r.

    memory1_memory2_pass_t r_q, r_d;
    excp_pass_t            excp_q, excp_d;
    mem2_st_e              st_q, st_d;
    logic [31:0]           hold_data_q, hold_data_d;

    logic        load;
    logic        data_rdy;
    logic        r_en;
    logic        pass_valid;
    logic [31:0] raw;
    logic [31:0] ext;
    logic [31:0] wb_data;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // A real load is one that reached the dcache and carries no exception.
    assign load = r_q.valid & r_q.dcache_req & r_q.is_mem & ~r_q.is_store & ~excp_q.valid;

    // Output decode: readiness of load data and the upstream stall.
    always_comb begin
        data_rdy = (st_q == ST_HELD) |
                   (load & dcache_data_valid & (st_q != ST_DROP));
        stall_o  = stall_i | (load & ~data_rdy) | (st_q == ST_DROP);
        r_en     = ~stall_o | flush_i;
    end

    // Input register next value: take the upstream bundle when allowed.
    always_comb begin
        r_d    = r_q;
        excp_d = excp_q;
        if (r_en) begin
            r_d    = pass_in;
            excp_d = excp_pass_in;
        end
    end

    // Next-state logic for the dcache response tracker.
    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE: begin
                if (load && !dcache_data_valid) begin
                    // A flushed load still has a response on its way.
                    st_d = flush_i ? ST_DROP : ST_WAIT;
                end else if (load && dcache_data_valid && stall_i && !flush_i) begin
                    st_d = ST_HELD;
                end
            end
            ST_WAIT: begin
                if (dcache_data_valid) begin
                    // Data arriving with a flush is simply dropped here.
                    st_d = (stall_i && !flush_i) ? ST_HELD : ST_IDLE;
                end else if (flush_i) begin
                    st_d = ST_DROP;
                end
            end
            ST_HELD: begin
                if (flush_i || !stall_i) begin
                    st_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (dcache_data_valid) begin
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // Hold buffer: capture the response only when writeback is stalled and
    // never overwrite data that is already held.
    always_comb begin
        hold_data_d = hold_data_q;
        if (load && dcache_data_valid && stall_i &&
            (st_q != ST_HELD) && (st_q != ST_DROP)) begin
            hold_data_d = dcache_rd_data;
        end
    end

    // State register, input register and hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            excp_q      <= '0;
            st_q        <= ST_IDLE;
            hold_data_q <= '0;
        end else begin
            r_q         <= r_d;
            excp_q      <= excp_d;
            st_q        <= st_d;
            hold_data_q <= hold_data_d;
        end
    end

    // Load alignment and sign/zero extension.
    always_comb begin
        raw = (st_q == ST_HELD) ? hold_data_q : dcache_rd_data;
        case (r_q.byte_en)
            2'd0:    sel_byte = raw[7:0];
            2'd1:    sel_byte = raw[15:8];
            2'd2:    sel_byte = raw[23:16];
            default: sel_byte = raw[31:24];
        endcase
        sel_half = r_q.byte_en[1] ? raw[31:16] : raw[15:0];
        case (r_q.byte_type)
            BYTE:      ext = {{24{r_q.is_signed & sel_byte[7]}}, sel_byte};
            HALF_WORD: ext = {{16{r_q.is_signed & sel_half[15]}}, sel_half};
            default:   ext = raw;
        endcase
    end

    // Writeback data select.
    always_comb begin
        if (r_q.is_wr_rd_pc_plus4) begin
            wb_data = r_q.pc_plus4;
        end else if (load) begin
            wb_data = ext;
        end else begin
            wb_data = r_q.ex_out;
        end
    end

    // Output bundles toward writeback and the forwarding logic.
    always_comb begin
        pass_valid = r_q.valid & ~stall_o & ~flush_i;

        pass_out          = '0;
        pass_out.valid    = pass_valid;
        pass_out.pc       = r_q.pc;
        pass_out.rd       = r_q.rd;
        pass_out.is_wr_rd = r_q.is_wr_rd;
        pass_out.wb_data  = wb_data;

        excp_pass_out       = excp_q;
        excp_pass_out.valid = excp_q.valid & pass_valid;

        fwd_req            = '0;
        fwd_req.valid      = r_q.valid & r_q.is_wr_rd & (r_q.rd != 5'd0) & ~excp_q.valid;
        fwd_req.idx        = r_q.rd;
        fwd_req.data_valid = ~load | data_rdy;
        fwd_req.data       = wb_data;
    end

endmodule
